// File: rtl/radar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radar_pkg
// Description : Shared types and constants for the ultrasonic echo timer
//               (FSM state encoding, result widths, cm divisor, timeout code).
// Revision    : 1.0 - initial release
// ============================================================================
package radar_pkg;

    localparam int ECHO_W = 16;
    localparam int DIST_W = 9;
    localparam int CM_DIV = 58;

    localparam logic [ECHO_W-1:0] TIMEOUT_CODE = 16'hFFFF;
    localparam logic [DIST_W-1:0] DIST_SAT     = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DIV       = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : echo_sync_edge
// Description : Two-flop synchronizer for the asynchronous echo pin plus a
//               one-flop edge detector producing single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the pin, then keep one extra delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Edge pulses from the synchronized level and its delayed copy
    always_comb begin
        rise = r_sync & ~r_prev;
        fall = ~r_sync & r_prev;
    end

endmodule
`default_nettype wire

// File: rtl/ultrasonic_echo_timer.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_echo_timer
// Description : Fires a sensor trigger pulse on start, times the returned echo
//               in microsecond ticks and reports the width with a done strobe.
//               Optional macro ECHO_DIST_CM_EN adds a serial divider that also
//               reports the distance in cm (echo_us / 58).
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_echo_timer
    import radar_pkg::*;
#(
    parameter int TRIG_CYCLES = 1000,
    parameter int TICK_DIV    = 100,
    parameter int MAX_US      = 30000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ECHO_W-1:0] echo_us,
    output logic [DIST_W-1:0] dist_cm
);

    localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TRIG_W-1:0] C_TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRE_W-1:0]  C_PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ECHO_W-1:0] C_US_LAST   = ECHO_W'(MAX_US - 1);

    state_t              r_state;
    state_t              w_next;
    logic [TRIG_W-1:0]   r_trig_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic [ECHO_W-1:0]   r_us;
    logic                r_timeout;
    logic [ECHO_W-1:0]   r_echo_us;
    logic                w_rise;
    logic                w_fall;
    logic                w_tick;
    logic                w_limit;
    logic [ECHO_W-1:0]   w_us_inc;

    echo_sync_edge u_sync (
        .clk   (clk),
        .reset (reset),
        .echo  (echo),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Tick generation; the us count including this cycle's tick is what gets
    // latched on a falling edge, so the cycle of the edge itself is counted
    always_comb begin
        w_tick   = (r_pre == C_PRE_LAST);
        w_us_inc = (w_tick && (r_us != '1)) ? r_us + 1'b1 : r_us;
        w_limit  = w_tick && (r_us == C_US_LAST);
    end

`ifdef ECHO_DIST_CM_EN
    logic [ECHO_W-1:0] r_rem;
    logic [DIST_W-1:0] r_quot;
    logic [DIST_W-1:0] r_dist_cm;
    logic              w_div_end;

    // Division finishes when the remainder drops below the divisor or the
    // quotient would overflow its 9 bits
    always_comb begin
        w_div_end = (r_rem < ECHO_W'(CM_DIV)) || (r_quot == '1);
    end

    assign dist_cm = r_dist_cm;
`else
    assign dist_cm = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_next = r_state;
        trig   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = TRIG;
            end
            TRIG: begin
                trig = 1'b1;
                if (r_trig_cnt == C_TRIG_LAST) w_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (w_rise)       w_next = MEASURE;
                else if (w_limit) w_next = DONE;
            end
            MEASURE: begin
`ifdef ECHO_DIST_CM_EN
                if (w_fall)       w_next = DIV;
`else
                if (w_fall)       w_next = DONE;
`endif
                else if (w_limit) w_next = DONE;
            end
`ifdef ECHO_DIST_CM_EN
            DIV: begin
                if (w_div_end) w_next = DONE;
            end
`endif
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    // Counters and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trig_cnt <= '0;
            r_pre      <= '0;
            r_us       <= '0;
            r_timeout  <= 1'b0;
            r_echo_us  <= '0;
`ifdef ECHO_DIST_CM_EN
            r_rem      <= '0;
            r_quot     <= '0;
            r_dist_cm  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_trig_cnt <= '0;
                end
                TRIG: begin
                    r_trig_cnt <= r_trig_cnt + 1'b1;
                    r_pre      <= '0;
                    r_us       <= '0;
                end
                WAIT_RISE, MEASURE: begin
                    if ((r_state == WAIT_RISE) && w_rise) begin
                        r_pre <= '0;
                        r_us  <= '0;
                    end else if ((r_state == MEASURE) && w_fall) begin
                        r_echo_us <= w_us_inc;
                        r_timeout <= 1'b0;
`ifdef ECHO_DIST_CM_EN
                        r_rem     <= w_us_inc;
                        r_quot    <= '0;
`endif
                    end else if (w_limit) begin
                        r_echo_us <= TIMEOUT_CODE;
                        r_timeout <= 1'b1;
`ifdef ECHO_DIST_CM_EN
                        r_dist_cm <= DIST_SAT;
`endif
                    end else begin
                        r_pre <= w_tick ? '0 : r_pre + 1'b1;
                        r_us  <= w_us_inc;
                    end
                end
`ifdef ECHO_DIST_CM_EN
                DIV: begin
                    if (w_div_end) begin
                        r_dist_cm <= r_quot;
                    end else begin
                        r_rem  <= r_rem - ECHO_W'(CM_DIV);
                        r_quot <= r_quot + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign timeout = r_timeout;
    assign echo_us = r_echo_us;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_echo_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonic_echo_timer
// Description : Self-checking bench for ultrasonic_echo_timer: a cycle-level
//               behavioural model compared every cycle, plus directed
//               scenarios with hand-computed literal results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_echo_timer;

    localparam int TRIG_CYCLES = 10;
    localparam int TICK_DIV    = 10;
    localparam int MAX_US      = 100;
    localparam int LIMIT_CYC   = MAX_US * TICK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        echo = 1'b0;
    logic        trig, busy, done, timeout;
    logic [15:0] echo_us;
    logic [8:0]  dist_cm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ultrasonic_echo_timer #(
        .TRIG_CYCLES (TRIG_CYCLES),
        .TICK_DIV    (TICK_DIV),
        .MAX_US      (MAX_US)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .echo    (echo),
        .trig    (trig),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .echo_us (echo_us),
        .dist_cm (dist_cm)
    );

`ifdef ECHO_DIST_CM_EN
    logic        start2 = 1'b0;
    logic        echo2 = 1'b0;
    logic        trig2, busy2, done2, timeout2;
    logic [15:0] echo_us2;
    logic [8:0]  dist_cm2;

    ultrasonic_echo_timer #(
        .TRIG_CYCLES (10),
        .TICK_DIV    (1),
        .MAX_US      (2000)
    ) u_dut2 (
        .clk     (clk),
        .reset   (reset),
        .start   (start2),
        .echo    (echo2),
        .trig    (trig2),
        .busy    (busy2),
        .done    (done2),
        .timeout (timeout2),
        .echo_us (echo_us2),
        .dist_cm (dist_cm2)
    );
`endif

    // ------------------------------------------------------------------
    // Behavioural model: phase plus elapsed-cycle count, widths by division
    // phase: 0 idle, 1 trigger, 2 wait for rise, 3 measure, 4 divide, 5 done
    // ------------------------------------------------------------------
    int          m_ph = 0;
    int          m_k = 0;
    int          m_dleft = 0;
    int          m_q = 0;
    logic [15:0] m_us = '0;
    logic        m_tmo = 1'b0;
    logic [8:0]  m_dist = '0;
    logic [8:0]  m_dist_pend = '0;
    logic        m_p1 = 1'b0, m_p2 = 1'b0, m_p3 = 1'b0;
    logic        m_rise, m_fall;

    always @(posedge clk) begin
        // pin level two and three edges back determines the edge seen now
        m_rise = m_p2 & ~m_p3;
        m_fall = ~m_p2 & m_p3;
        if (reset) begin
            m_ph = 0; m_k = 0; m_us = '0; m_tmo = 1'b0; m_dist = '0;
            m_p1 = 1'b0; m_p2 = 1'b0; m_p3 = 1'b0;
        end else begin
            case (m_ph)
                0: if (start) begin m_ph = 1; m_k = 0; end
                1: begin
                    m_k++;
                    if (m_k == TRIG_CYCLES) begin m_ph = 2; m_k = 0; end
                end
                2: begin
                    if (m_rise) begin
                        m_ph = 3; m_k = 0;
                    end else begin
                        m_k++;
                        if (m_k == LIMIT_CYC) begin
                            m_ph = 5; m_tmo = 1'b1; m_us = 16'hFFFF;
`ifdef ECHO_DIST_CM_EN
                            m_dist = 9'h1FF;
`endif
                        end
                    end
                end
                3: begin
                    m_k++;
                    if (m_fall) begin
                        m_us  = 16'(m_k / TICK_DIV);
                        m_tmo = 1'b0;
`ifdef ECHO_DIST_CM_EN
                        m_q = int'(m_us) / 58;
                        if (m_q > 511) m_q = 511;
                        m_dist_pend = 9'(m_q);
                        m_dleft = m_q + 1;
                        m_ph = 4;
`else
                        m_ph = 5;
`endif
                    end else if (m_k == LIMIT_CYC) begin
                        m_ph = 5; m_tmo = 1'b1; m_us = 16'hFFFF;
`ifdef ECHO_DIST_CM_EN
                        m_dist = 9'h1FF;
`endif
                    end
                end
                4: begin
                    m_dleft--;
                    if (m_dleft == 0) begin m_dist = m_dist_pend; m_ph = 5; end
                end
                default: m_ph = 0;
            endcase
            m_p3 = m_p2; m_p2 = m_p1; m_p1 = echo;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [28:0] act, exp_v;
        act   = {trig, busy, done, timeout, echo_us, dist_cm};
        exp_v = {(m_ph == 1), (m_ph != 0), (m_ph == 5), m_tmo, m_us, m_dist};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t {trig,busy,done,tmo,us,cm}: got %h expected %h",
                     $time, act, exp_v);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start, then count the cycles trig is seen high
    task automatic trig_phase(output int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (trig === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            n++;
            @(negedge clk);
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done after %0d cycles, required done", budget);
        end
    endtask

    initial begin
        int n, nd, nb;
        cyc(3);
        chk("reset_trig", trig, 0);
        chk("reset_busy", busy, 0);
        chk("reset_echo_us", echo_us, 0);
        reset = 1'b0;
        cyc(2);

        // Normal echo: 250 cycles high -> 25 us
        trig_phase(n);
        chk("s1_trig_width", n, 10);
        cyc(20);
        echo = 1'b1;
        cyc(250);
        echo = 1'b0;
        wait_done(50, n);
        chk("s1_echo_us", echo_us, 25);
        chk("s1_timeout", timeout, 0);
        @(negedge clk);
        chk("s1_busy_after_done", busy, 0);
        chk("s1_done_single", done, 0);
        cyc(5);

        // No echo: timeout exactly MAX_US*TICK_DIV cycles after wait entry
        trig_phase(n);
        wait_done(2000, n);
        chk("s2_done_gap", n, 1000);
        chk("s2_timeout", timeout, 1);
        chk("s2_echo_us", echo_us, 16'hFFFF);
        cyc(5);

        // Echo stuck high: measurement timeout
        trig_phase(n);
        cyc(5);
        echo = 1'b1;
        wait_done(2500, n);
        chk("s3_timeout", timeout, 1);
        chk("s3_echo_us", echo_us, 16'hFFFF);
        cyc(990);
        echo = 1'b0;
        cyc(10);

        // Echo already high at wait entry: only the second rise counts
        echo = 1'b1;
        cyc(5);
        trig_phase(n);
        cyc(5);
        echo = 1'b0;
        cyc(10);
        echo = 1'b1;
        cyc(57);
        echo = 1'b0;
        wait_done(50, n);
        chk("s4_echo_us", echo_us, 5);
        chk("s4_timeout", timeout, 0);
        cyc(5);

        // Starts during MEASURE and on the done cycle are ignored
        trig_phase(n);
        cyc(3);
        echo = 1'b1;
        cyc(20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(79);
        echo = 1'b0;
        wait_done(50, n);
        chk("s5_echo_us", echo_us, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; nb = 0;
        repeat (30) begin
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
            @(negedge clk);
        end
        chk("s5_extra_done", nd, 0);
        chk("s5_busy_after", nb, 0);

        // Reset in the middle of a measurement
        trig_phase(n);
        cyc(3);
        echo = 1'b1;
        cyc(30);
        reset = 1'b1;
        echo = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("s6_outputs", {trig, busy, done, timeout, echo_us, dist_cm}, 0);
        nd = 0;
        repeat (200) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("s6_no_done", nd, 0);

`ifdef ECHO_DIST_CM_EN
        // Distance: 1170 us -> 20 cm, done only after the divider finishes
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc(15);
        echo2 = 1'b1;
        cyc(1170);
        echo2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("s7_done_seen", done2, 1);
        chk("s7_echo_us", echo_us2, 1170);
        chk("s7_dist_cm", dist_cm2, 20);
        chk("s7_div_latency", (n > 21), 1);
`endif

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
